// File: rtl/hex_nib_cnt.sv
`default_nettype none
// ============================================================================
// Module      : hex_nib_cnt
// Description : Nibble-loadable saturating up/down counter with terminal-count
//               pulse and sticky under/overflow flag for the HEX2BIN path.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_nib_cnt #(
  parameter int NIB = 2,
  parameter int SW  = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            SCLR,
  input  logic            LD,
  input  logic [SW-1:0]   LSEL,
  input  logic [3:0]      D,
  input  logic            CE,
  input  logic            UP,
  output logic [4*NIB-1:0] Q,
  output logic            ZD,
  output logic            TC,
  output logic            ERR
);

  localparam int W = 4 * NIB;
  localparam logic [W-1:0] c_ZERO  = '0;
  localparam logic [W-1:0] c_ONE   = W'(1);
  localparam logic [W-1:0] c_MAX   = '1;
  localparam logic [W-1:0] c_MAXM1 = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] r_q;
  logic         r_tc;
  logic         r_err;

  logic [W-1:0] w_q_load;
  logic [W-1:0] w_q_nxt;
  logic         w_tc_nxt;
  logic         w_err_nxt;
  logic         w_zero;
  logic         w_full;

  // An out-of-range LSEL matches no nibble, so the load leaves Q untouched.
  for (genvar i = 0; i < NIB; i++) begin : g_nib
    logic w_sel;
    assign w_sel                = (LSEL == SW'(i));
    assign w_q_load[4*i +: 4]   = w_sel ? D : r_q[4*i +: 4];
  end

  assign w_zero = (r_q == c_ZERO);
  assign w_full = (r_q == c_MAX);

  always_comb begin
    w_q_nxt   = r_q;
    w_tc_nxt  = 1'b0;
    w_err_nxt = r_err;
    if (SCLR) begin
      w_q_nxt   = c_ZERO;
      w_err_nxt = 1'b0;
    end else if (LD) begin
      w_q_nxt   = w_q_load;
      w_err_nxt = 1'b0;
    end else if (CE) begin
      if (UP) begin
        if (w_full) begin
          w_err_nxt = 1'b1;
        end else begin
          w_q_nxt  = r_q + c_ONE;
          w_tc_nxt = (r_q == c_MAXM1);
        end
      end else begin
        if (w_zero) begin
          w_err_nxt = 1'b1;
        end else begin
          w_q_nxt  = r_q - c_ONE;
          w_tc_nxt = (r_q == c_ONE);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_q   <= c_ZERO;
      r_tc  <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_tc  <= w_tc_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign Q   = r_q;
  assign ZD  = w_zero;
  assign TC  = r_tc;
  assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_hex_nib_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tb_hex_nib_cnt
// Description : Self-checking bench for hex_nib_cnt (NIB=2 table, NIB=3 seqs).
// ============================================================================
module tb_hex_nib_cnt;

  typedef struct packed {
    logic       sclr;
    logic       ld;
    logic [1:0] lsel;
    logic [3:0] d;
    logic       ce;
    logic       up;
    logic [11:0] q;
    logic       tc;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [11:0] q;
    logic        zd;
    logic        tc;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NIB=2 instance
  logic       clr2 = 1'b0, sclr2 = 1'b0, ld2 = 1'b0, ce2 = 1'b0, up2 = 1'b0;
  logic [0:0] lsel2 = '0;
  logic [3:0] d2 = '0;
  logic [7:0] q2;
  logic       zd2, tc2, err2;

  hex_nib_cnt #(.NIB(2)) dut2 (
    .CLK(clk), .CLR(clr2), .SCLR(sclr2), .LD(ld2), .LSEL(lsel2), .D(d2),
    .CE(ce2), .UP(up2), .Q(q2), .ZD(zd2), .TC(tc2), .ERR(err2)
  );

  // NIB=3 instance
  logic       clr3 = 1'b0, sclr3 = 1'b0, ld3 = 1'b0, ce3 = 1'b0, up3 = 1'b0;
  logic [1:0] lsel3 = '0;
  logic [3:0] d3 = '0;
  logic [11:0] q3;
  logic       zd3, tc3, err3;

  hex_nib_cnt #(.NIB(3)) dut3 (
    .CLK(clk), .CLR(clr3), .SCLR(sclr3), .LD(ld3), .LSEL(lsel3), .D(d3),
    .CE(ce3), .UP(up3), .Q(q3), .ZD(zd3), .TC(tc3), .ERR(err3)
  );

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [11:0] q, input logic zd,
                         input logic tc, input logic err, input exp_t e);
    chk({name, ".Q"},   q,         e.q);
    chk({name, ".ZD"},  12'(zd),   12'(e.zd));
    chk({name, ".TC"},  12'(tc),   12'(e.tc));
    chk({name, ".ERR"}, 12'(err),  12'(e.err));
  endtask

  function automatic void add(input logic sclr, input logic ld, input logic [1:0] lsel,
                              input logic [3:0] d, input logic ce, input logic up,
                              input logic [11:0] q, input logic tc, input logic err);
    tbl.push_back({sclr, ld, lsel, d, ce, up, q, tc, err});
  endfunction

  function automatic exp_t mk_exp(input logic [11:0] q, input logic tc, input logic err);
    return {q, (q == 12'h0), tc, err};
  endfunction

  task automatic step3(input string name, input logic sclr, input logic ld,
                       input logic [1:0] lsel, input logic [3:0] d, input logic ce,
                       input logic up, input logic [11:0] q, input logic tc, input logic err);
    exp_t e;
    @(negedge clk);
    sclr3 = sclr; ld3 = ld; lsel3 = lsel; d3 = d; ce3 = ce; up3 = up;
    sb.push_back(mk_exp(q, tc, err));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk_all(name, q3, zd3, tc3, err3, e);
  endtask

  initial begin
    exp_t e;

    // sclr ld lsel d ce up | q tc err
    add(0, 1, 1, 4'h3, 0, 0, 12'h030, 0, 0);
    add(0, 1, 0, 4'hA, 0, 0, 12'h03A, 0, 0);
    add(0, 1, 1, 4'h0, 0, 0, 12'h00A, 0, 0);
    add(0, 1, 0, 4'h3, 0, 0, 12'h003, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h002, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h001, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h000, 1, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h000, 0, 1);
    add(0, 0, 0, 4'h0, 0, 1, 12'h000, 0, 1);
    add(0, 1, 0, 4'h5, 0, 0, 12'h005, 0, 0);
    add(0, 1, 1, 4'hF, 0, 0, 12'h0F5, 0, 0);
    add(0, 1, 0, 4'hE, 0, 0, 12'h0FE, 0, 0);
    add(0, 0, 0, 4'h0, 1, 1, 12'h0FF, 1, 0);
    add(0, 0, 0, 4'h0, 1, 1, 12'h0FF, 0, 1);
    add(0, 0, 0, 4'h0, 1, 0, 12'h0FE, 0, 1);
    add(0, 1, 1, 4'h1, 0, 0, 12'h01E, 0, 0);
    add(0, 1, 0, 4'h0, 0, 0, 12'h010, 0, 0);
    add(0, 1, 0, 4'h7, 1, 0, 12'h017, 0, 0);
    add(1, 1, 1, 4'h9, 0, 0, 12'h000, 0, 0);
    add(0, 1, 0, 4'h0, 0, 0, 12'h000, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h000, 0, 1);
    add(1, 0, 0, 4'h0, 0, 0, 12'h000, 0, 0);
    add(0, 1, 0, 4'h1, 0, 0, 12'h001, 0, 0);
    add(0, 0, 0, 4'h0, 1, 1, 12'h002, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h001, 0, 0);
    add(0, 0, 0, 4'h0, 1, 0, 12'h000, 1, 0);

    // Asynchronous reset: outputs clear before any clock edge.
    #1;
    clr2 = 1'b1; clr3 = 1'b1;
    #2;
    chk_all("reset2", 12'(q2), zd2, tc2, err2, mk_exp(12'h000, 0, 0));
    chk_all("reset3", q3, zd3, tc3, err3, mk_exp(12'h000, 0, 0));
    @(negedge clk);
    clr2 = 1'b0; clr3 = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      sclr2 = tbl[i].sclr; ld2 = tbl[i].ld; lsel2 = tbl[i].lsel[0]; d2 = tbl[i].d;
      ce2 = tbl[i].ce; up2 = tbl[i].up;
      sb.push_back(mk_exp(tbl[i].q, tbl[i].tc, tbl[i].err));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all($sformatf("vec%0d", i), 12'(q2), zd2, tc2, err2, e);
    end
    @(negedge clk);
    sclr2 = 0; ld2 = 0; ce2 = 0;

    // NIB=3: load 0x123, out-of-range LSEL, count down, async clear mid-cycle.
    step3("n3_ld0",   0, 1, 2'd0, 4'h3, 0, 0, 12'h003, 0, 0);
    step3("n3_ld1",   0, 1, 2'd1, 4'h2, 0, 0, 12'h023, 0, 0);
    step3("n3_ld2",   0, 1, 2'd2, 4'h1, 0, 0, 12'h123, 0, 0);
    step3("n3_ldoor", 0, 1, 2'd3, 4'h9, 0, 0, 12'h123, 0, 0);
    step3("n3_dec1",  0, 0, 2'd0, 4'h0, 1, 0, 12'h122, 0, 0);
    step3("n3_dec2",  0, 0, 2'd0, 4'h0, 1, 0, 12'h121, 0, 0);
    #2;
    clr3 = 1'b1;
    #1;
    chk_all("n3_clrmid", q3, zd3, tc3, err3, mk_exp(12'h000, 0, 0));
    @(negedge clk);
    clr3 = 1'b0; ce3 = 1'b0;

    // Sticky ERR cleared by CLR.
    step3("n3_under", 0, 0, 2'd0, 4'h0, 1, 0, 12'h000, 0, 1);
    #2;
    clr3 = 1'b1;
    #1;
    chk_all("n3_clrerr", q3, zd3, tc3, err3, mk_exp(12'h000, 0, 0));
    @(negedge clk);
    clr3 = 1'b0; ce3 = 1'b0;

    // Pending TC pulse killed by CLR.
    step3("n3_ld1b",  0, 1, 2'd0, 4'h1, 0, 0, 12'h001, 0, 0);
    step3("n3_term",  0, 0, 2'd0, 4'h0, 1, 0, 12'h000, 1, 0);
    #2;
    clr3 = 1'b1;
    #1;
    chk_all("n3_clrtc", q3, zd3, tc3, err3, mk_exp(12'h000, 0, 0));
    @(negedge clk);
    clr3 = 1'b0; ce3 = 1'b0;

    // Overflow at full 12-bit width.
    step3("n3_f0",    0, 1, 2'd0, 4'hE, 0, 0, 12'h00E, 0, 0);
    step3("n3_f1",    0, 1, 2'd1, 4'hF, 0, 0, 12'h0FE, 0, 0);
    step3("n3_f2",    0, 1, 2'd2, 4'hF, 0, 0, 12'hFFE, 0, 0);
    step3("n3_inc",   0, 0, 2'd0, 4'h0, 1, 1, 12'hFFF, 1, 0);
    step3("n3_over",  0, 0, 2'd0, 4'h0, 1, 1, 12'hFFF, 0, 1);
    step3("n3_hold",  0, 0, 2'd0, 4'h0, 0, 0, 12'hFFF, 0, 1);
    step3("n3_ldclr", 0, 1, 2'd3, 4'h0, 0, 0, 12'hFFF, 0, 0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish within 100000");
    $fatal(1);
  end

endmodule
`default_nettype wire
